// File: rtl/enc4x2_arb_if.sv
// Request/select/acknowledge bundle between requesters, arbiter and consumer.
interface enc4x2_arb_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       req_in;
    logic [1:0]       enc_out;
    logic             enc_valid;
    logic             enc_ready;
    logic [3:0]       ack_out;
    logic             dup_out;
    logic [CNT_W-1:0] grant_cnt;

    modport master (
        output req_in, enc_ready,
        input  enc_out, enc_valid, ack_out, dup_out, grant_cnt
    );

    modport slave (
        input  req_in, enc_ready,
        output enc_out, enc_valid, ack_out, dup_out, grant_cnt
    );
endinterface

// File: rtl/enc4x2_arb.sv
// 4-to-2 request encoder/arbiter: pending requests are serialized onto a
// 2-bit select with a valid/ready handshake and a one-hot acknowledge.
module enc4x2_arb #(
    parameter int ROUND_ROBIN = 1,
    parameter int CNT_W       = 8
) (
    input logic         clk,
    input logic         reset,
    enc4x2_arb_if.slave bus
);
    typedef enum logic {IDLE, OFFER} state_t;

    state_t           state_q, state_n;
    logic [3:0]       pend_q, pend_n;
    logic [1:0]       ptr_q, ptr_n;
    logic [1:0]       enc_q, enc_n;
    logic             valid_q, valid_n;
    logic [3:0]       ack_q, ack_n;
    logic             dup_q, dup_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [3:0]       clr;
    logic [1:0]       sel;
    logic [1:0]       idx;
    logic             found;

    // Rotating search starts at ptr; fixed search starts at bit 3.
    always_comb begin
        sel   = 2'b00;
        idx   = 2'b00;
        found = 1'b0;
        if (ROUND_ROBIN != 0) begin
            for (int i = 0; i < 4; i++) begin
                idx = ptr_q + 2'(i);
                if (!found && pend_q[idx]) begin
                    sel   = idx;
                    found = 1'b1;
                end
            end
        end else begin
            for (int i = 3; i >= 0; i--) begin
                if (!found && pend_q[i]) begin
                    sel   = 2'(i);
                    found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_n = state_q;
        enc_n   = enc_q;
        valid_n = valid_q;
        ptr_n   = ptr_q;
        cnt_n   = cnt_q;
        ack_n   = 4'b0000;
        clr     = 4'b0000;
        unique case (state_q)
            IDLE: begin
                if (|pend_q) begin
                    enc_n   = sel;
                    valid_n = 1'b1;
                    state_n = OFFER;
                end
            end
            OFFER: begin
                if (bus.enc_ready) begin
                    ack_n   = 4'b0001 << enc_q;
                    clr     = 4'b0001 << enc_q;
                    ptr_n   = enc_q + 2'd1;
                    cnt_n   = cnt_q + CNT_W'(1);
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        // A request landing on the bit being cleared survives the clear.
        pend_n = (pend_q & ~clr) | bus.req_in;
        dup_n  = |(bus.req_in & pend_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 4'b0000;
            ptr_q   <= 2'b00;
            enc_q   <= 2'b00;
            valid_q <= 1'b0;
            ack_q   <= 4'b0000;
            dup_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_n;
            pend_q  <= pend_n;
            ptr_q   <= ptr_n;
            enc_q   <= enc_n;
            valid_q <= valid_n;
            ack_q   <= ack_n;
            dup_q   <= dup_n;
            cnt_q   <= cnt_n;
        end
    end

    assign bus.enc_out   = enc_q;
    assign bus.enc_valid = valid_q;
    assign bus.ack_out   = ack_q;
    assign bus.dup_out   = dup_q;
    assign bus.grant_cnt = cnt_q;
endmodule

// File: doc/enc4x2_arb.md
Name: enc4x2_arb

Overview:
- Inverse counterpart of the control unit's 2-to-4 decoder.
- Collects up to four one-hot request lines from control-unit sources and serializes them into a 2-bit encoded select.
- Presents the select on a valid/ready handshake and acknowledges the granted requester with a one-hot pulse.
- Sits between step/flag logic raising requests and any consumer of a 2-bit select (register select, ALU op select).

Parameters:
- ROUND_ROBIN, 1: 1 = rotating priority starting after the last grant; 0 = fixed priority with bit 3 highest, down to bit 0.
- CNT_W, 8: width of the grant counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_in  input  4  request pulses or levels, one bit per source.
- enc_out  output  2  encoded index of the granted source.
- enc_valid  output  1  enc_out holds a valid grant.
- enc_ready  input  1  consumer accepts enc_out.
- ack_out  output  4  one-hot, one-cycle pulse to the granted source on handshake.
- dup_out  output  1  one-cycle pulse: a request arrived on a bit that was already pending.
- grant_cnt  output  CNT_W  count of completed handshakes.

Behaviour:
- Reset: reset is synchronous and active-high, sampled on the rising clk edge. On reset:
  - pending = 0, ptr = 0, state = IDLE
  - enc_out = 2'b00, enc_valid = 0, ack_out = 4'b0000, dup_out = 0, grant_cnt = 0
- Reset mid-OFFER: drops the offer and all pending requests. No ack_out is issued.
- Capture, every cycle: pending_next = (pending & ~clear_mask) | req_in.
  - clear_mask is one-hot of enc_out on a handshake cycle, else 0.
  - A req_in bit equal to the bit being cleared in the same cycle stays pending. Set wins over clear.
- dup_out = 1 the cycle after any req_in bit arrives while the same pending bit is already 1 and not being cleared. The duplicate is merged, not queued.
- IDLE state:
  - If the registered pending != 0, select index sel, set enc_out = sel and enc_valid = 1, go to OFFER.
  - Otherwise stay in IDLE with enc_valid = 0.
  - Requests arriving this cycle are not visible until next cycle.
- Selection when ROUND_ROBIN = 1: search pending from ptr upward, modulo 4; the first set bit wins.
- Selection when ROUND_ROBIN = 0: the highest set index wins; ptr is ignored.
- OFFER state:
  - enc_out and enc_valid are held stable while enc_ready = 0. New requests do not change the offer.
  - On a handshake (enc_valid & enc_ready):
    - ack_out = one-hot(enc_out) on the next cycle, for exactly one cycle.
    - pending[enc_out] is cleared, subject to the set-wins rule.
    - ptr = enc_out + 1, mod 4 (2'b11 wraps to 2'b00).
    - grant_cnt increments, wrapping at 2^CNT_W - 1 to 0.
    - enc_valid = 0, return to IDLE.
- Latency and throughput:
  - req_in high at edge N: pending set at N+1, enc_valid = 1 at N+2.
  - Handshake at edge M: ack_out pulses during M+1 to M+2; the next offer earliest at M+2.
  - Maximum throughput is one grant per 2 cycles.
- enc_ready while enc_valid = 0 is ignored.
- All outputs are registered; there is no combinational path from input to output.

Test Plan:
- Reset with req_in = 4'b1111 held high: while reset = 1, all outputs are 0. One cycle after reset falls, pending = 4'b1111; one cycle later enc_valid = 1, enc_out = 2'b00.
- Single request, ROUND_ROBIN = 1: pulse req_in = 4'b0100 at cycle 0, enc_ready = 1. enc_valid = 1 with enc_out = 2'b10 at cycle 2; ack_out = 4'b0100 at cycle 3; grant_cnt = 1; ptr = 3.
- Rotation: hold req_in = 4'b1111 with enc_ready = 1. The grant sequence is 0, 1, 2, 3, 0, spaced 2 cycles apart. ack_out pulses match each grant.
- Fixed priority, ROUND_ROBIN = 0: pending = 4'b0110. Grants are 2 then 1. A new req_in = 4'b1000 arriving during the first offer is granted before bit 1.
- Backpressure and duplicate:
  - Hold enc_ready = 0 for 5 cycles while an offer for index 1 is pending; enc_out stays 2'b01.
  - Re-pulse req_in[1] during this window: dup_out pulses once and there is no second grant for it.
  - Pulse req_in[1] on the exact handshake cycle: bit 1 is re-offered afterwards.
- Wrap and reset mid-OFFER:
  - CNT_W = 2 with 5 handshakes: grant_cnt reads 1, 2, 3, 0, 1.
  - Assert reset during OFFER: enc_valid drops the next cycle, no ack_out is issued, and pending = 0.
